// File: rtl/ring_sync_model_if.sv
// Control and observation bundle for the clocked ring model.
// The master drives firing/load controls; the slave returns ring state and counters.
interface ring_sync_model_if #(
    parameter int STAGES = 50,
    parameter int CNT_W  = 16
);
    localparam int PW = $clog2(STAGES);

    logic              en;
    logic              mode;
    logic              load;
    logic [STAGES-1:0] load_val;
    logic [STAGES-1:0] state;
    logic [STAGES-1:0] excited;
    logic              stalled;
    logic [CNT_W-1:0]  fire_count;
    logic [CNT_W-1:0]  period_count;
    logic [PW-1:0]     rr_ptr;

    modport master (
        output en, mode, load, load_val,
        input  state, excited, stalled, fire_count, period_count, rr_ptr
    );

    modport slave (
        input  en, mode, load, load_val,
        output state, excited, stalled, fire_count, period_count, rr_ptr
    );
endinterface

// File: rtl/ring_sync_model.sv
// Clocked inverter/buffer ring: stage i reads n[i] and drives n[i+1 mod STAGES].
// Excited stages fire all at once (mode=0) or one per edge in round-robin (mode=1).
module ring_sync_model #(
    parameter int                STAGES   = 50,
    parameter logic [STAGES-1:0] INV_MASK = STAGES'(1),
    parameter int                CNT_W    = 16
) (
    input logic               clk,
    input logic               reset,
    ring_sync_model_if.slave  bus
);
    localparam int PW = $clog2(STAGES);

    logic [STAGES-1:0]   r_state;
    logic [CNT_W-1:0]    r_fc;
    logic [CNT_W-1:0]    r_pc;
    logic [PW-1:0]       r_ptr;

    logic [STAGES-1:0]   w_succ;
    logic [STAGES-1:0]   w_tgt;
    logic [STAGES-1:0]   w_exc;
    logic [2*STAGES-1:0] w_dbl;
    logic [STAGES-1:0]   w_rot;
    logic                w_found;
    logic [PW:0]         w_j;
    logic [PW:0]         w_sum;
    logic [PW-1:0]       w_k;
    logic [PW-1:0]       w_kn;
    logic [STAGES-1:0]   w_onehot;
    logic [STAGES-1:0]   w_fire;
    logic [STAGES-1:0]   w_flip;
    logic [STAGES-1:0]   w_next;
    logic [CNT_W-1:0]    w_nfire;
    logic                w_rise;

    // Stage i is excited when its output n[i+1] differs from its target.
    assign w_succ = {r_state[0], r_state[STAGES-1:1]};
    assign w_tgt  = r_state ^ INV_MASK;
    assign w_exc  = w_succ ^ w_tgt;

    // Rotate so bit 0 is the stage at rr_ptr, then take the first set bit.
    assign w_dbl = {w_exc, w_exc} >> r_ptr;
    assign w_rot = w_dbl[STAGES-1:0];

    always_comb begin
        w_found = 1'b0;
        w_j     = '0;
        for (int j = 0; j < STAGES; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_j     = (PW+1)'(j);
            end
        end
    end

    assign w_sum = {1'b0, r_ptr} + w_j;
    assign w_k   = (w_sum >= (PW+1)'(STAGES))
                 ? PW'(w_sum - (PW+1)'(STAGES))
                 : PW'(w_sum);
    assign w_kn  = (w_k == PW'(STAGES-1)) ? '0 : w_k + 1'b1;

    assign w_onehot = STAGES'(1) << w_k;
    assign w_fire   = bus.mode ? (w_found ? w_onehot : '0) : w_exc;

    // Firing stage i flips n[i+1], which then equals its target.
    assign w_flip = {w_fire[STAGES-2:0], w_fire[STAGES-1]};
    assign w_next = r_state ^ w_flip;
    assign w_rise = ~r_state[0] & w_next[0];

    always_comb begin
        w_nfire = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_nfire = w_nfire + CNT_W'(w_fire[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= '0;
            r_fc    <= '0;
            r_pc    <= '0;
            r_ptr   <= '0;
        end else if (bus.load) begin
            r_state <= bus.load_val;
            r_ptr   <= '0;
        end else if (bus.en) begin
            r_state <= w_next;
            r_fc    <= r_fc + w_nfire;
            if (w_rise) begin
                r_pc <= r_pc + 1'b1;
            end
            if (bus.mode && w_found) begin
                r_ptr <= w_kn;
            end
        end
    end

    assign bus.state        = r_state;
    assign bus.excited      = w_exc;
    assign bus.stalled      = ~|w_exc;
    assign bus.fire_count   = r_fc;
    assign bus.period_count = r_pc;
    assign bus.rr_ptr       = r_ptr;
endmodule

// File: tb/tb_ring_sync_model.sv
// Bench for ring_sync_model: three parameter sets, directed scenarios and
// randomized runs compared against a rule-level ring model.
module tb_ring_sync_model;
    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;

    always #5 clk = ~clk;

    localparam logic [255:0] MA = 256'h1;
    localparam logic [255:0] MB = 256'h1;
    localparam logic [255:0] MC = 256'h0;

    ring_sync_model_if #(.STAGES(50), .CNT_W(16)) ifa ();
    ring_sync_model_if #(.STAGES(8),  .CNT_W(4))  ifb ();
    ring_sync_model_if #(.STAGES(8),  .CNT_W(8))  ifc ();

    ring_sync_model #(.STAGES(50), .INV_MASK(50'h1), .CNT_W(16)) u_a (
        .clk(clk), .reset(rst_a), .bus(ifa)
    );
    ring_sync_model #(.STAGES(8), .INV_MASK(8'h01), .CNT_W(4)) u_b (
        .clk(clk), .reset(rst_b), .bus(ifb)
    );
    ring_sync_model #(.STAGES(8), .INV_MASK(8'h00), .CNT_W(8)) u_c (
        .clk(clk), .reset(rst_c), .bus(ifc)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference ring: bit i of ms is signal n[i].
    logic [255:0] ms;
    int mfc, mpc, mptr;

    task automatic m_rst();
        ms = '0; mfc = 0; mpc = 0; mptr = 0;
    endtask

    function automatic logic [255:0] m_exc(input int ns, input logic [255:0] mask);
        logic [255:0] ex;
        ex = '0;
        for (int i = 0; i < ns; i++)
            ex[i] = ms[(i + 1) % ns] != (ms[i] ^ mask[i]);
        return ex;
    endfunction

    task automatic m_step(input int ns, input logic [255:0] mask, input int cw,
                          input logic e, input logic m, input logic l,
                          input logic [255:0] lv);
        logic [255:0] ex, nw;
        int cnt, k, lim;
        logic found;
        lim = (1 << cw) - 1;
        if (l) begin
            ms   = lv & ((256'd1 << ns) - 1);
            mptr = 0;
        end else if (e) begin
            ex = m_exc(ns, mask);
            nw = ms;
            cnt = 0;
            if (!m) begin
                for (int i = 0; i < ns; i++)
                    if (ex[i]) begin
                        nw[(i + 1) % ns] = ms[i] ^ mask[i];
                        cnt++;
                    end
            end else begin
                found = 1'b0;
                for (int j = 0; j < ns; j++) begin
                    k = (mptr + j) % ns;
                    if (!found && ex[k]) begin
                        found = 1'b1;
                        nw[(k + 1) % ns] = ms[k] ^ mask[k];
                        cnt = 1;
                        mptr = (k + 1) % ns;
                    end
                end
            end
            if (!ms[0] && nw[0]) mpc = (mpc + 1) & lim;
            mfc = (mfc + cnt) & lim;
            ms = nw;
        end
    endtask

    task automatic cmp_a();
        logic [255:0] ex;
        ex = m_exc(50, MA);
        chk("a.state",   256'(ifa.state), ms);
        chk("a.excited", 256'(ifa.excited), ex);
        chk("a.stalled", 256'(ifa.stalled), 256'(ex == '0));
        chk("a.fires",   256'(ifa.fire_count), 256'(mfc));
        chk("a.periods", 256'(ifa.period_count), 256'(mpc));
        chk("a.rr_ptr",  256'(ifa.rr_ptr), 256'(mptr));
    endtask

    task automatic cmp_b();
        logic [255:0] ex;
        ex = m_exc(8, MB);
        chk("b.state",   256'(ifb.state), ms);
        chk("b.excited", 256'(ifb.excited), ex);
        chk("b.stalled", 256'(ifb.stalled), 256'(ex == '0));
        chk("b.fires",   256'(ifb.fire_count), 256'(mfc));
        chk("b.periods", 256'(ifb.period_count), 256'(mpc));
        chk("b.rr_ptr",  256'(ifb.rr_ptr), 256'(mptr));
    endtask

    task automatic cmp_c();
        logic [255:0] ex;
        ex = m_exc(8, MC);
        chk("c.state",   256'(ifc.state), ms);
        chk("c.excited", 256'(ifc.excited), ex);
        chk("c.stalled", 256'(ifc.stalled), 256'(ex == '0));
        chk("c.fires",   256'(ifc.fire_count), 256'(mfc));
        chk("c.periods", 256'(ifc.period_count), 256'(mpc));
        chk("c.rr_ptr",  256'(ifc.rr_ptr), 256'(mptr));
    endtask

    task automatic step_a(input logic e, m, l, input logic [255:0] v);
        ifa.en = e; ifa.mode = m; ifa.load = l; ifa.load_val = v[49:0];
        @(posedge clk);
        m_step(50, MA, 16, e, m, l, v);
        #1;
        cmp_a();
    endtask

    task automatic step_b(input logic e, m, l, input logic [255:0] v);
        ifb.en = e; ifb.mode = m; ifb.load = l; ifb.load_val = v[7:0];
        @(posedge clk);
        m_step(8, MB, 4, e, m, l, v);
        #1;
        cmp_b();
    endtask

    task automatic step_c(input logic e, m, l, input logic [255:0] v);
        ifc.en = e; ifc.mode = m; ifc.load = l; ifc.load_val = v[7:0];
        @(posedge clk);
        m_step(8, MC, 8, e, m, l, v);
        #1;
        cmp_c();
    endtask

    function automatic logic [255:0] rnd_vec();
        return {192'd0, $urandom, $urandom};
    endfunction

    logic [49:0] tr [0:100];
    int          fsave;

    initial begin
        {ifa.en, ifa.mode, ifa.load} = '0; ifa.load_val = '0;
        {ifb.en, ifb.mode, ifb.load} = '0; ifb.load_val = '0;
        {ifc.en, ifc.mode, ifc.load} = '0; ifc.load_val = '0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        #1;
        m_rst(); cmp_a(); cmp_b(); cmp_c();
        chk("c.stalled_at_reset", 256'(ifc.stalled), 256'd1);
        #16;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Default ring, round-robin from reset.
        m_rst();
        tr[0] = '0;
        for (int c = 1; c <= 150; c++) begin
            step_a(1'b1, 1'b1, 1'b0, '0);
            if (c <= 100) tr[c] = ms[49:0];
            if (c == 1) begin
                chk("a.c1_state", 256'(ifa.state), 256'h2);
                chk("a.c1_fires", 256'(ifa.fire_count), 256'd1);
            end
            if (c == 50) begin
                chk("a.c50_state",   256'(ifa.state), (256'd1 << 50) - 1);
                chk("a.c50_periods", 256'(ifa.period_count), 256'd1);
            end
            if (c == 100) begin
                chk("a.c100_state", 256'(ifa.state), 256'd0);
                chk("a.c100_fires", 256'(ifa.fire_count), 256'd100);
            end
            if (c == 150) chk("a.c150_periods", 256'(ifa.period_count), 256'd2);
        end

        // Parallel from reset retraces the round-robin run.
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        m_rst();
        rst_a = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            chk("a.par_one_excited", 256'($countones(ifa.excited)), 256'd1);
            step_a(1'b1, 1'b0, 1'b0, '0);
            chk("a.par_trace", 256'(ifa.state), 256'(tr[c]));
        end

        for (int c = 0; c < 300; c++)
            step_a($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 19) == 0, rnd_vec());

        // 8-stage ring, single inverter at stage 0.
        m_rst();
        step_b(1'b0, 1'b0, 1'b1, 256'h55);
        chk("b.load_excited", 256'(ifb.excited), 256'hFE);
        step_b(1'b1, 1'b0, 1'b0, '0);
        chk("b.par_state", 256'(ifb.state), 256'hA8);
        chk("b.par_fires", 256'(ifb.fire_count), 256'd7);

        @(negedge clk);
        rst_b = 1'b1;
        #1;
        m_rst();
        rst_b = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            step_b(1'b1, 1'b1, 1'b0, '0);
            if (c == 15) chk("b.fires_15", 256'(ifb.fire_count), 256'd15);
            if (c == 16) chk("b.fires_wrap", 256'(ifb.fire_count), 256'd0);
        end

        // Asynchronous reset in the middle of cycle 7.
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        m_rst();
        rst_b = 1'b0;
        for (int c = 1; c <= 6; c++) step_b(1'b1, 1'b1, 1'b0, '0);
        #3;
        rst_b = 1'b1;
        #1;
        chk("b.rst_state",   256'(ifb.state), 256'd0);
        chk("b.rst_fires",   256'(ifb.fire_count), 256'd0);
        chk("b.rst_periods", 256'(ifb.period_count), 256'd0);
        chk("b.rst_rr_ptr",  256'(ifb.rr_ptr), 256'd0);
        m_rst();
        @(negedge clk);
        rst_b = 1'b0;
        step_b(1'b1, 1'b1, 1'b0, '0);
        chk("b.resume_state", 256'(ifb.state), 256'h2);
        chk("b.resume_fires", 256'(ifb.fire_count), 256'd1);

        // Load wins over enable.
        step_b(1'b1, 1'b1, 1'b0, '0);
        fsave = mfc;
        step_b(1'b1, 1'b1, 1'b1, 256'h3C);
        chk("b.ld_en_state",  256'(ifb.state), 256'h3C);
        chk("b.ld_en_fires",  256'(ifb.fire_count), 256'(fsave));
        chk("b.ld_en_rr_ptr", 256'(ifb.rr_ptr), 256'd0);

        for (int c = 0; c < 400; c++)
            step_b($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 9) == 0, rnd_vec());

        // All-buffer ring is stalled from reset.
        m_rst();
        for (int c = 0; c < 10; c++)
            step_c(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0);
        chk("c.stall_state",  256'(ifc.state), 256'd0);
        chk("c.stall_fires",  256'(ifc.fire_count), 256'd0);
        chk("c.stall_rr_ptr", 256'(ifc.rr_ptr), 256'd0);
        step_c(1'b0, 1'b0, 1'b1, 256'h01);
        chk("c.ld_stalled",  256'(ifc.stalled), 256'd0);
        chk("c.ld_excited0", 256'(ifc.excited[0]), 256'd1);

        for (int c = 0; c < 300; c++)
            step_c($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 14) == 0, rnd_vec());

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ring_sync_model.md
Name: ring_sync_model

Overview:
- Clocked, parametrised successor to the fixed 50-stage inverter/buffer ring benchmark.
- Holds the ring's signal vector in registers and fires excited stages on each enabled clock edge, in either parallel mode (all excited stages) or sequential round-robin mode (one stage).
- Stage length, the set of inverting stages and the counter width are parameters.
- Adds state load, excitation/deadlock visibility and fire/period counters for benchmark runs inside the sync-models flow.

Parameters:
STAGES, 50, number of ring stages and signals; legal range 2..256.
INV_MASK, 1 (STAGES bits), bit i=1 makes stage i an inverter, bit i=0 makes it a buffer.
CNT_W, 16, width of fire_count and period_count.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  fire excited stages this cycle
mode  input  1  0 = parallel firing, 1 = sequential round-robin (one stage per cycle)
load  input  1  synchronous load of load_val into the ring state
load_val  input  STAGES  state image; bit i is n[i]
state  output  STAGES  registered ring signals n[0..STAGES-1]
excited  output  STAGES  combinational; bit i set when stage i is excited
stalled  output  1  combinational; high when excited is all zero
fire_count  output  CNT_W  total stage firings, wraps modulo 2^CNT_W
period_count  output  CNT_W  count of n[0] 0->1 transitions, wraps
rr_ptr  output  clog2(STAGES)  sequential-mode search start index

Behaviour:
- Topology: stage i reads n[i] and drives n[(i+1) mod STAGES].
- Target value for stage i: t_i = n[i] XOR INV_MASK[i].
- excited[i] = (n[(i+1) mod STAGES] != t_i).
- Reset (asynchronous, active-high): state=0, fire_count=0, period_count=0, rr_ptr=0. excited/stalled immediately reflect the all-zero state. Reset asserted mid-run aborts everything; no partial update survives.
- Priority per edge: reset > load > en.
- load=1: state<=load_val; rr_ptr<=0; counters unchanged; no firing that cycle. period_count does not count a 0->1 change of n[0] caused by load.
- en=0 and load=0: all registers hold.
- en=1, mode=0 (parallel): for every excited i, n[(i+1) mod STAGES] <= t_i, all evaluated from pre-edge state. fire_count += popcount(excited), mod 2^CNT_W. rr_ptr unchanged.
- en=1, mode=1 (sequential): find the first excited index k scanning rr_ptr, rr_ptr+1, ... wrapping modulo STAGES. Fire only stage k. fire_count += 1. rr_ptr <= (k+1) mod STAGES.
- en=1 with stalled=1: no state change, counters hold, rr_ptr holds.
- period_count += 1 on any enabled firing edge where n[0] goes 0->1, in either mode.
- Latency: a firing is visible on state one cycle after the sampling edge; excited and stalled update in the same cycle as state.
- Counter wrap: an all-ones value plus an increment gives the expected modular result. This includes a parallel-mode add larger than 1 across the wrap.
- Mode may change on any cycle and takes effect at the next edge; rr_ptr is preserved across mode changes.
- Odd popcount(INV_MASK): the ring oscillates and is never stalled from any state.
- Even popcount(INV_MASK): the ring can reach a stable state; stalled then stays high until load or reset.

Test Plan:
- Defaults, reset released, en=1, mode=1 -> cycle 1: state[1]=1, fire_count=1. After 50 enabled cycles: state=all ones, period_count=1. After 100 cycles: state=all zero, fire_count=100. After 150 cycles: period_count=2.
- Defaults, mode=0 from reset -> exactly one stage excited each cycle; the trace matches the mode=1 trace cycle-for-cycle.
- STAGES=8, INV_MASK=8'h01, load load_val=8'b01010101, then one parallel edge -> every excited stage fires at once; fire_count equals the pre-edge popcount(excited); state matches the hand-computed image.
- STAGES=8, INV_MASK=0, reset -> stalled=1 immediately. en=1 for 10 cycles -> state, fire_count and rr_ptr unchanged. load 8'h01 -> stalled=0; stage 0 excited.
- CNT_W=4, defaults, run 16 sequential fires -> fire_count wraps 15->0. Assert reset during cycle 7 of a run -> all outputs return to zero asynchronously, and run resumes from cycle 1 behaviour after release.
- load and en both asserted in the same cycle -> only load_val appears on state; fire_count unchanged; rr_ptr=0.
